// File: rtl/cla_pkg.sv
// Shared constants and types for the registered carry-lookahead adder.
// Default geometry: 8-bit words split into two 4-bit lookahead groups.
package cla_pkg;

    localparam int CLA_WIDTH = 8;
    localparam int CLA_BLOCK = 4;

    typedef logic [CLA_WIDTH-1:0] cla_word_t;

endpackage : cla_pkg

// File: rtl/cla_block.sv
// One first-level lookahead group: per-bit generate/propagate, expanded
// internal carries, sum bits, and the group generate/propagate pair.
module cla_block
    import cla_pkg::*;
#(
    parameter int BLOCK = CLA_BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             groupG,
    output logic             groupP
);

    logic [BLOCK-1:0] gen;
    logic [BLOCK-1:0] prop;
    logic [BLOCK-1:0] carry;
    logic             term;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Each carry is the full sum-of-products over g/p/cin, so no carry is
    // built from its neighbour and the depth stays flat across the group.
    // NOTE: always_comb with a default assignment first for every variable
    // keeps the logic purely combinational; no path leaves a value unassigned.
    always_comb begin
        carry  = '0;
        term   = 1'b0;
        groupG = 1'b0;
        carry[0] = cin;
        for (int i = 1; i < BLOCK; i++) begin
            term = cin;
            for (int k = 0; k < i; k++) term = term & prop[k];
            carry[i] = term;
            for (int j = 0; j < i; j++) begin
                term = gen[j];
                for (int k = j + 1; k < i; k++) term = term & prop[k];
                carry[i] = carry[i] | term;
            end
        end
        for (int j = 0; j < BLOCK; j++) begin
            term = gen[j];
            for (int k = j + 1; k < BLOCK; k++) term = term & prop[k];
            groupG = groupG | term;
        end
    end

    assign groupP = &prop;
    assign sum    = prop ^ carry;

endmodule : cla_block

// File: rtl/cla_adder.sv
// Registered WIDTH-bit two-level carry-lookahead adder:
// {carryOut, dataOut} <= dataA + dataB + carryIn, one cycle latency.
module cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int BLOCK = CLA_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic             carryIn,
    output logic [WIDTH-1:0] dataOut,
    output logic             carryOut
);

    localparam int NGROUP = WIDTH / BLOCK;

    logic [NGROUP-1:0] groupG;
    logic [NGROUP-1:0] groupP;
    logic [NGROUP:0]   groupCin;
    logic [WIDTH-1:0]  sumComb;

    assign groupCin[0] = carryIn;

    for (genvar gi = 0; gi < NGROUP; gi++) begin : gBlock
        cla_block #(.BLOCK(BLOCK)) uBlock (
            .a      (dataA[gi*BLOCK +: BLOCK]),
            .b      (dataB[gi*BLOCK +: BLOCK]),
            .cin    (groupCin[gi]),
            .sum    (sumComb[gi*BLOCK +: BLOCK]),
            .groupG (groupG[gi]),
            .groupP (groupP[gi])
        );
    end

    // Second level: each group carry-in is expanded over all lower G/P and
    // carryIn, e.g. c8 = G1 | P1.G0 | P1.P0.cin.
    for (genvar gi = 1; gi <= NGROUP; gi++) begin : gLookahead
        logic carryAcc;
        logic termAcc;

        always_comb begin
            termAcc = carryIn;
            for (int k = 0; k < gi; k++) termAcc = termAcc & groupP[k];
            carryAcc = termAcc;
            for (int j = 0; j < gi; j++) begin
                termAcc = groupG[j];
                for (int k = j + 1; k < gi; k++) termAcc = termAcc & groupP[k];
                carryAcc = carryAcc | termAcc;
            end
        end

        assign groupCin[gi] = carryAcc;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dataOut  <= '0;
            carryOut <= 1'b0;
        end else begin
            dataOut  <= sumComb;
            carryOut <= groupCin[NGROUP];
        end
    end

endmodule : cla_adder

// File: tb/tb_cla_adder.sv
// Directed and random checks of cla_adder: reset behaviour, carry paths,
// extremes, asynchronous mid-stream reset, and a random sum sweep.
module tb_cla_adder;
    import cla_pkg::*;

    logic      clk;
    logic      rst_n;
    cla_word_t dataA;
    cla_word_t dataB;
    logic      carryIn;
    cla_word_t dataOut;
    logic      carryOut;

    int vecCount  = 0;
    int missCount = 0;

    cla_adder #(.WIDTH(CLA_WIDTH), .BLOCK(CLA_BLOCK)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dataA    (dataA),
        .dataB    (dataB),
        .carryIn  (carryIn),
        .dataOut  (dataOut),
        .carryOut (carryOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL %s: got {carryOut,dataOut}=%h, expected %h", tag, got, exp);
        end
    endtask

    // Drive on the falling edge, capture on the rising edge, sample 1 ns later.
    task automatic applyVec(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic cin, input logic [8:0] exp);
        @(negedge clk);
        dataA   = a;
        dataB   = b;
        carryIn = cin;
        @(posedge clk);
        #1;
        check(tag, {carryOut, dataOut}, exp);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;

        rst_n   = 1'b0;
        dataA   = 8'hFF;
        dataB   = 8'hFF;
        carryIn = 1'b1;

        #1;
        check("reset_t0", {carryOut, dataOut}, 9'h000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", {carryOut, dataOut}, 9'h000);
        end

        @(negedge clk);
        rst_n = 1'b1;

        applyVec("basic_1_2_c1", 8'd1, 8'd2, 1'b1, 9'd4);
        applyVec("basic_2_5",    8'd2, 8'd5, 1'b0, 9'd7);
        applyVec("basic_5_6",    8'd5, 8'd6, 1'b0, 9'd11);

        applyVec("carry_ff_01",  8'hFF, 8'h01, 1'b0, 9'h100);
        applyVec("carry_0f_c1",  8'h0F, 8'h00, 1'b1, 9'h010);
        applyVec("carry_grp_hi", 8'hF0, 8'h10, 1'b0, 9'h100);
        applyVec("prop_ff_00",   8'hFF, 8'h00, 1'b1, 9'h100);

        applyVec("max_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
        applyVec("zero",         8'h00, 8'h00, 1'b0, 9'h000);

        // Asynchronous clear between edges, then release before the next edge.
        applyVec("pre_reset_80_80", 8'h80, 8'h80, 1'b0, 9'h100);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", {carryOut, dataOut}, 9'h000);
        @(negedge clk);
        dataA   = 8'h03;
        dataB   = 8'h04;
        carryIn = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;
        check("post_release", {carryOut, dataOut}, 9'h007);

        for (int i = 0; i < 4000; i++) begin
            ra = 8'($urandom_range(255));
            rb = 8'($urandom_range(255));
            rc = 1'($urandom_range(1));
            applyVec("random", ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule : tb_cla_adder

// File: doc/cla_adder.md
# cla_adder

Registered 8-bit carry-lookahead adder. Computes `dataA + dataB + carryIn` through a two-level lookahead network with no ripple chain, and registers the 8-bit sum and carry-out on the clock. It serves as the arithmetic primitive for datapath blocks that need a single-cycle, fixed-latency add with carry in and carry out.

## Interface
Parameters:
- `WIDTH`, 8: operand width. Must be a multiple of `BLOCK`.
- `BLOCK`, 4: bits per first-level lookahead group.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `dataA`  input  WIDTH: addend A, unsigned.
- `dataB`  input  WIDTH: addend B, unsigned.
- `carryIn`  input  1: carry into bit 0.
- `dataOut`  output  WIDTH: registered sum bits `[WIDTH-1:0]`.
- `carryOut`  output  1: registered carry out of the MSB (sum bit `WIDTH`).

## Operation
- Per bit: `g[i] = dataA[i] & dataB[i]`, `p[i] = dataA[i] ^ dataB[i]`.
- First level, one group per `BLOCK` bits:
  - Internal carries are expanded lookahead equations, e.g. `c1 = g0 | p0·cin` and `c2 = g1 | p1·g0 | p1·p0·cin`. No carry is derived from the previous bit's carry.
  - Each group also outputs a group generate `G` and group propagate `P`, where P is the AND of all p.
- Second level: group carry-ins come from the group G/P signals and `carryIn`, again as expanded lookahead equations. For the default configuration, `c4 = G0 | P0·cin` and `c8 = G1 | P1·G0 | P1·P0·cin`.
- Sum: `s[i] = p[i] ^ c[i]`. Carry-out is the carry out of the top group.
- Arithmetic: unsigned, modulo 2^WIDTH, with overflow reported only in `carryOut`. `{carryOut, dataOut}` must equal `dataA + dataB + carryIn` exactly for all 2^17 input combinations.
- No internal state other than the output register. There is no handshake: every edge captures the current inputs.
- X/Z on inputs propagates. No special handling is required.

## Timing
- Latency is 1 cycle. Inputs sampled at edge N appear on `dataOut`/`carryOut` after edge N and hold until edge N+1.
- Throughput is one add per cycle.
- Reset: `rst_n` low immediately forces `dataOut = 0` and `carryOut = 0`, independent of `clk`.
  - Reset asserted mid-operation discards the captured result.
  - After `rst_n` rises, the first rising edge captures the inputs present at that edge.
- The combinational path from inputs to the register must contain no ripple chain longer than one `BLOCK`. The critical path is per-bit p/g, then group G/P, then second-level carry, then group-internal carry, then sum XOR.

## Structure
- Shared package `cla_pkg`:
  - constants `CLA_WIDTH = 8` and `CLA_BLOCK = 4`;
  - typedef `cla_word_t` as `logic [CLA_WIDTH-1:0]`.
- Sub-module `cla_block`: a `BLOCK`-bit lookahead group.
  - Inputs: a, b, cin.
  - Outputs: sum, group G, group P.
- Top level contains:
  - `WIDTH/BLOCK` instances of `cla_block`;
  - a second-level lookahead unit, written inline as a generate loop of expanded AND-OR terms;
  - the output register with asynchronous clear.

## Test plan
- Reset: hold `rst_n` = 0 with dataA = 8'hFF, dataB = 8'hFF, carryIn = 1 and toggle `clk`. Required: `dataOut` = 0 and `carryOut` = 0 throughout.
- Basic sequence, one vector per cycle, each checked one edge after capture:
  - 1 + 2 + cin 1 → dataOut 4, carryOut 0;
  - 2 + 5 + 0 → 7, carryOut 0;
  - 5 + 6 + 0 → 11, carryOut 0.
- Carry through both groups:
  - 8'hFF + 8'h01 + 0 → dataOut 8'h00, carryOut 1;
  - 8'h0F + 8'h00 + 1 → 8'h10, carryOut 0.
- Maximum input: 8'hFF + 8'hFF + 1 → dataOut 8'hFF, carryOut 1. Zero input: 0 + 0 + 0 → 0, carryOut 0.
- Reset mid-stream: apply 8'h80 + 8'h80, then drop `rst_n` between edges. Required: outputs go to 0 immediately, with no clock edge needed. After release, the next edge shows the current sum.
- Exhaustive or random sweep: checker compares `{carryOut, dataOut}` against `dataA + dataB + carryIn` captured one cycle earlier, over all 131072 combinations.
